// File: rtl/apb_pkg.sv
// Shared definitions for the APB register-file completer.
//   apb_state_e : completer FSM states
//   STRB_WIDTH  : number of byte strobes for a given data width
//   ADDR_LSB    : number of byte-offset address bits for a given data width
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_state_e;

  function automatic int unsigned STRB_WIDTH(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned ADDR_LSB(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter for the APB completer.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (clears the count)
//   load_i     : load load_val_i (takes priority over decrement)
//   load_val_i : number of wait states for the coming access phase
//   dec_i      : decrement request; saturates at zero
//   zero_o     : count is zero
module apb_wait_counter #(
  parameter int unsigned WS_WIDTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [WS_WIDTH-1:0] load_val_i,
  input  logic                dec_i,
  output logic                zero_o
);

  logic [WS_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_regfile_completer.sv
// APB4 completer in front of NUM_REGS control/status registers.
//   PCLK/PRESET       : clock, synchronous active-high reset
//   PSEL..PSTRB       : APB4 requester-driven signals
//   PRDATA/PREADY/PSLVERR : APB4 completer response
//   wait_cfg          : wait states for the next transfer, sampled in SETUP
//   hw_status         : live values returned when reading read-only registers
//   reg_q             : flat writable register contents (read-only slots read 0)
module apb_regfile_completer
  import apb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = 16'h8000,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
  parameter int unsigned           WS_WIDTH   = 4
) (
  input  logic                                PCLK,
  input  logic                                PRESET,
  input  logic                                PSEL,
  input  logic                                PENABLE,
  input  logic                                PWRITE,
  input  logic [ADDR_WIDTH-1:0]               PADDR,
  input  logic [DATA_WIDTH-1:0]               PWDATA,
  input  logic [STRB_WIDTH(DATA_WIDTH)-1:0]   PSTRB,
  output logic [DATA_WIDTH-1:0]               PRDATA,
  output logic                                PREADY,
  output logic                                PSLVERR,
  input  logic [WS_WIDTH-1:0]                 wait_cfg,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]      hw_status,
  output logic [NUM_REGS*DATA_WIDTH-1:0]      reg_q
);

  localparam int unsigned StrbW   = STRB_WIDTH(DATA_WIDTH);
  localparam int unsigned AddrLsb = ADDR_LSB(DATA_WIDTH);
  localparam int unsigned IdxW    = ADDR_WIDTH - AddrLsb;

  localparam logic [ADDR_WIDTH-1:0] LsbMask  = ADDR_WIDTH'((2 ** AddrLsb) - 1);
  localparam logic [IdxW:0]         NumRegsW = (IdxW + 1)'(NUM_REGS);
  // RO mask padded to the full index space so any decoded index selects a defined bit
  localparam logic [(2 ** IdxW)-1:0] RoFull  = (2 ** IdxW)'(RO_MASK);

  // Latched request; widths follow the instance parameters
  typedef struct packed {
    logic [IdxW-1:0]       idx;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [StrbW-1:0]      strb;
  } req_t;

  apb_state_e            state_q;
  req_t                  req_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  cnt_zero;
  logic                  complete;
  logic [IdxW-1:0]       setup_idx;
  logic                  err_setup;
  logic [DATA_WIDTH-1:0] hw_val, reg_val;

  apb_wait_counter #(
    .WS_WIDTH (WS_WIDTH)
  ) u_wait_counter (
    .clk_i      (PCLK),
    .rst_i      (PRESET),
    .load_i     (state_q == APB_SETUP),
    .load_val_i (wait_cfg),
    .dec_i      ((state_q == APB_ACCESS) && PSEL),
    .zero_o     (cnt_zero)
  );

  // Decode is computed from the live bus in SETUP, where PADDR/PWRITE equal the latched values
  assign setup_idx = PADDR[ADDR_WIDTH-1:AddrLsb];
  assign err_setup = (|(PADDR & LsbMask))
                   | ({1'b0, setup_idx} >= NumRegsW)
                   | (PWRITE & RoFull[setup_idx]);

  assign complete = (state_q == APB_ACCESS) && cnt_zero && PSEL && PENABLE;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= APB_IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      unique case (state_q)
        APB_IDLE: begin
          // PENABLE without PSEL, or PENABLE already high, never starts a transfer
          if (PSEL && !PENABLE) state_q <= APB_SETUP;
        end
        APB_SETUP: begin
          state_q <= APB_ACCESS;
          req_q   <= '{idx: setup_idx, write: PWRITE, wdata: PWDATA, strb: PSTRB};
          err_q   <= err_setup;
        end
        APB_ACCESS: begin
          // Completion returns via IDLE; a following setup phase is picked up from there
          if (!PSEL || complete) state_q <= APB_IDLE;
        end
        default: state_q <= APB_IDLE;
      endcase

      // err_q covers RO targets, so RO slots are never written here
      if (complete && req_q.write && !err_q) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (req_q.idx == IdxW'(i)) begin
            for (int b = 0; b < StrbW; b++) begin
              if (req_q.strb[b]) regs_q[i][b*8 +: 8] <= req_q.wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    hw_val  = '0;
    reg_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_q.idx == IdxW'(i)) begin
        hw_val  = hw_status[i*DATA_WIDTH +: DATA_WIDTH];
        reg_val = regs_q[i];
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
    end
  end

  assign PREADY  = complete;
  assign PSLVERR = complete && err_q;
  assign PRDATA  = (complete && !err_q && !req_q.write)
                 ? (RoFull[req_q.idx] ? hw_val : reg_val) : '0;

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Directed self-checking bench for apb_regfile_completer (default parameters).
module tb_apb_regfile_completer;

  logic         pclk;
  logic         preset;
  logic         psel;
  logic         penable;
  logic         pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata;
  logic         pready;
  logic         pslverr;
  logic [3:0]   wait_cfg;
  logic [511:0] hw_status;
  logic [511:0] reg_q;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [16];

  apb_regfile_completer u_dut (
    .PCLK      (pclk),
    .PRESET    (preset),
    .PSEL      (psel),
    .PENABLE   (penable),
    .PWRITE    (pwrite),
    .PADDR     (paddr),
    .PWDATA    (pwdata),
    .PSTRB     (pstrb),
    .PRDATA    (prdata),
    .PREADY    (pready),
    .PSLVERR   (pslverr),
    .wait_cfg  (wait_cfg),
    .hw_status (hw_status),
    .reg_q     (reg_q)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reg_q must mirror the model; slot 15 is read-only and always reads 0
  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("%s reg_q[%0d]", tag, i), reg_q[i*32 +: 32],
               (i == 15) ? 32'h0 : model[i]);
    end
  endtask

  task automatic bus_idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
      psel    = 1'b0;
      penable = 1'b0;
    end
  endtask

  // One APB transfer; expected latency is (ws + 2) bus cycles after the setup cycle.
  // wait_cfg is scrambled after it has been sampled to show it no longer matters.
  task automatic apb_xfer(input string tag, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [3:0] ws, input logic [31:0] exp_rdata,
                          input logic exp_err);
    int          lat;
    logic [31:0] got_rd;
    logic        got_err;
    lat     = 0;
    got_rd  = '0;
    got_err = 1'b0;
    @(posedge pclk); #1;
    psel     = 1'b1;
    penable  = 1'b0;
    pwrite   = wr;
    paddr    = addr;
    pwdata   = wdata;
    pstrb    = strb;
    wait_cfg = ws;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 2) wait_cfg = ~ws;
      @(negedge pclk);
      if (pready) begin
        lat     = n;
        got_rd  = prdata;
        got_err = pslverr;
        break;
      end
      @(posedge pclk); #1;
    end
    check_eq({tag, " latency"}, 32'(lat), 32'(ws) + 32'd2);
    check_eq({tag, " pslverr"}, {31'b0, got_err}, {31'b0, exp_err});
    if (!wr) check_eq({tag, " prdata"}, got_rd, exp_rdata);
  endtask

  // Write to 0x0C with 5 wait states, observe two ACCESS cycles, then abort
  // either by dropping PSEL or by asserting PRESET.
  task automatic aborted_write(input string tag, input logic use_reset);
    @(posedge pclk); #1;
    psel     = 1'b1;
    penable  = 1'b0;
    pwrite   = 1'b1;
    paddr    = 8'h0C;
    pwdata   = 32'hFFFF_FFFF;
    pstrb    = 4'hF;
    wait_cfg = 4'd5;
    for (int n = 1; n <= 3; n++) begin
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      check_eq($sformatf("%s pready c%0d", tag, n), {31'b0, pready}, 32'h0);
    end
    @(posedge pclk); #1;
    if (use_reset) begin
      preset = 1'b1;
    end else begin
      psel    = 1'b0;
      penable = 1'b0;
    end
    @(negedge pclk);
    check_eq({tag, " pready abort"}, {31'b0, pready}, 32'h0);
    @(posedge pclk); #1;
    preset  = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    check_eq({tag, " pready after"}, {31'b0, pready}, 32'h0);
    check_eq({tag, " pslverr after"}, {31'b0, pslverr}, 32'h0);
    check_eq({tag, " prdata after"}, prdata, 32'h0);
  endtask

  localparam logic [31:0] Hw15 = 32'hA5A5_000F;

  initial begin
    preset   = 1'b1;
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    pstrb    = '0;
    wait_cfg = '0;
    for (int i = 0; i < 16; i++) begin
      hw_status[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
      model[i] = 32'h0;
    end

    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    @(negedge pclk);
    check_eq("reset pready", {31'b0, pready}, 32'h0);
    check_eq("reset pslverr", {31'b0, pslverr}, 32'h0);
    check_eq("reset prdata", prdata, 32'h0);
    check_regs("reset");

    // Read every register back-to-back, zero wait states
    for (int i = 0; i < 16; i++) begin
      apb_xfer($sformatf("rd%0d", i), 1'b0, 8'(i * 4), '0, '0, 4'd0,
               (i == 15) ? Hw15 : 32'h0, 1'b0);
    end
    bus_idle(1);

    // Byte-lane write with 3 wait states, then read back
    apb_xfer("wr strb", 1'b1, 8'h04, 32'hDEAD_BEEF, 4'b0101, 4'd3, '0, 1'b0);
    model[1] = 32'h00AD_00EF;
    apb_xfer("rd strb", 1'b0, 8'h04, '0, '0, 4'd1, 32'h00AD_00EF, 1'b0);
    bus_idle(1);
    check_regs("strb");

    // Illegal accesses: RO, misaligned+out of range, out of range, misaligned in range
    apb_xfer("wr ro", 1'b1, 8'h3C, 32'h1111_1111, 4'hF, 4'd0, '0, 1'b1);
    apb_xfer("wr 0x41", 1'b1, 8'h41, 32'h2222_2222, 4'hF, 4'd0, '0, 1'b1);
    apb_xfer("wr oor", 1'b1, 8'h40, 32'h3333_3333, 4'hF, 4'd0, '0, 1'b1);
    apb_xfer("wr 0x06", 1'b1, 8'h06, 32'h4444_4444, 4'hF, 4'd2, '0, 1'b1);
    apb_xfer("rd oor", 1'b0, 8'h40, '0, '0, 4'd0, 32'h0, 1'b1);
    bus_idle(1);
    check_regs("errors");

    // Back-to-back write then read, then a PSTRB=0 no-op write
    apb_xfer("b2b wr", 1'b1, 8'h08, 32'h1234_5678, 4'hF, 4'd0, '0, 1'b0);
    model[2] = 32'h1234_5678;
    apb_xfer("b2b rd", 1'b0, 8'h08, '0, '0, 4'd0, 32'h1234_5678, 1'b0);
    apb_xfer("wr nostrb", 1'b1, 8'h08, 32'hFFFF_FFFF, 4'h0, 4'd0, '0, 1'b0);
    apb_xfer("rd nostrb", 1'b0, 8'h08, '0, '0, 4'd0, 32'h1234_5678, 1'b0);
    bus_idle(1);

    // Abort by PSEL drop: no write, FSM back in IDLE
    aborted_write("abort psel", 1'b0);
    bus_idle(1);
    check_regs("abort psel");
    apb_xfer("rd after abort", 1'b0, 8'h0C, '0, '0, 4'd0, 32'h0, 1'b0);
    bus_idle(1);

    // Abort by reset: no write and every writable register reloads
    aborted_write("abort reset", 1'b1);
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    check_regs("abort reset");
    apb_xfer("rd after reset", 1'b0, 8'h04, '0, '0, 4'd0, 32'h0, 1'b0);
    bus_idle(1);

    // PENABLE without PSEL must not start anything
    @(posedge pclk); #1;
    psel    = 1'b0;
    penable = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge pclk);
      check_eq($sformatf("penable only c%0d", n), {31'b0, pready}, 32'h0);
      @(posedge pclk); #1;
    end
    penable = 1'b0;
    apb_xfer("rd after penable", 1'b0, 8'h3C, '0, '0, 4'd0, Hw15, 1'b0);
    bus_idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
